// File: rtl/sprite_draw_arbiter.sv
// Round-robin arbiter that hands sprite draw slots to controller channels and
// tracks the game start / game-over lifecycle around them.
module sprite_draw_arbiter #(
    parameter int NUM_CH  = 2,
    parameter int STATE_W = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        go_n,
    input  logic                        collision,
    input  logic [NUM_CH*STATE_W-1:0]   ch_state,
    input  logic [NUM_CH-1:0]           ch_req,
    input  logic                        draw_done,
    output logic [STATE_W-1:0]          cur_state,
    output logic [$clog2(NUM_CH)-1:0]   cur_ch,
    output logic [NUM_CH-1:0]           ch_grant,
    output logic                        draw_valid,
    output logic                        started,
    output logic                        game_over,
    output logic                        draw_timeout
);

    localparam int CH_W = $clog2(NUM_CH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        DRAW = 2'd2,
        OVER = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [CH_W-1:0]     ptr, ptr_nxt;
    logic [15:0]         wd_cnt, wd_cnt_nxt;
    logic                coll_lat, coll_lat_nxt;

    logic [STATE_W-1:0]  cur_state_nxt;
    logic [CH_W-1:0]     cur_ch_nxt;
    logic [NUM_CH-1:0]   ch_grant_nxt;
    logic                draw_valid_nxt;
    logic                started_nxt;
    logic                game_over_nxt;
    logic                draw_timeout_nxt;

    logic [STATE_W-1:0]  states [NUM_CH];
    logic                any_req;
    logic [CH_W-1:0]     sel;
    logic [CH_W:0]       sum;
    logic                coll_hit;
    logic                wd_expired;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
        assign states[k] = ch_state[k*STATE_W +: STATE_W];
    end

    // Scan offsets from highest to lowest so the last hit is the channel
    // nearest to ptr going upward.
    always_comb begin
        any_req = 1'b0;
        sel     = '0;
        sum     = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + (CH_W+1)'(i);
            if (sum >= (CH_W+1)'(NUM_CH)) begin
                sum = sum - (CH_W+1)'(NUM_CH);
            end
            if (ch_req[sum[CH_W-1:0]]) begin
                any_req = 1'b1;
                sel     = sum[CH_W-1:0];
            end
        end
    end

    assign wd_expired = (wd_cnt == 16'(TIMEOUT - 1));
    assign coll_hit   = coll_lat | collision;

    always_comb begin
        state_nxt        = state;
        ptr_nxt          = ptr;
        wd_cnt_nxt       = wd_cnt;
        coll_lat_nxt     = coll_lat;
        cur_state_nxt    = cur_state;
        cur_ch_nxt       = cur_ch;
        ch_grant_nxt     = ch_grant;
        draw_valid_nxt   = draw_valid;
        started_nxt      = started;
        game_over_nxt    = game_over;
        draw_timeout_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (!go_n) begin
                    started_nxt = 1'b1;
                    state_nxt   = ARB;
                end
            end
            ARB: begin
                // A collision here wins over any pending request.
                if (collision) begin
                    game_over_nxt = 1'b1;
                    state_nxt     = OVER;
                end else if (any_req) begin
                    cur_state_nxt  = states[sel];
                    cur_ch_nxt     = sel;
                    ch_grant_nxt   = NUM_CH'(1) << sel;
                    draw_valid_nxt = 1'b1;
                    ptr_nxt        = (sel == CH_W'(NUM_CH - 1)) ? '0 : sel + CH_W'(1);
                    wd_cnt_nxt     = '0;
                    coll_lat_nxt   = 1'b0;
                    state_nxt      = DRAW;
                end
            end
            DRAW: begin
                wd_cnt_nxt   = wd_cnt + 16'd1;
                coll_lat_nxt = coll_hit;
                if (draw_done || wd_expired) begin
                    draw_valid_nxt   = 1'b0;
                    ch_grant_nxt     = '0;
                    draw_timeout_nxt = !draw_done;
                    if (coll_hit) begin
                        game_over_nxt = 1'b1;
                        state_nxt     = OVER;
                    end else begin
                        state_nxt = ARB;
                    end
                end
            end
            OVER: begin
                draw_valid_nxt = 1'b0;
                ch_grant_nxt   = '0;
                game_over_nxt  = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= IDLE;
            ptr          <= '0;
            wd_cnt       <= '0;
            coll_lat     <= 1'b0;
            cur_state    <= '0;
            cur_ch       <= '0;
            ch_grant     <= '0;
            draw_valid   <= 1'b0;
            started      <= 1'b0;
            game_over    <= 1'b0;
            draw_timeout <= 1'b0;
        end else begin
            state        <= state_nxt;
            ptr          <= ptr_nxt;
            wd_cnt       <= wd_cnt_nxt;
            coll_lat     <= coll_lat_nxt;
            cur_state    <= cur_state_nxt;
            cur_ch       <= cur_ch_nxt;
            ch_grant     <= ch_grant_nxt;
            draw_valid   <= draw_valid_nxt;
            started      <= started_nxt;
            game_over    <= game_over_nxt;
            draw_timeout <= draw_timeout_nxt;
        end
    end

endmodule

// File: doc/sprite_draw_arbiter.md
SPRITE_DRAW_ARBITER -- requirements
Module: sprite_draw_arbiter

Interface
REQ-001 Parameter NUM_CH, default 2: number of sprite controller channels; legal range 2 to 8.
REQ-002 Parameter STATE_W, default 4: width of each channel's draw-state code.
REQ-003 Parameter TIMEOUT, default 1023: maximum DRAW cycles without draw_done before the draw is aborted; legal range 1 to 65535.
REQ-004 clk  input  1  clock; all logic is rising-edge triggered.
REQ-005 resetn  input  1  synchronous, active-low reset.
REQ-006 go_n  input  1  active-low start key; level-sampled.
REQ-007 collision  input  1  active-high collision indication from the game logic.
REQ-008 ch_state  input  NUM_CH*STATE_W  packed state codes; channel k occupies bits [k*STATE_W +: STATE_W].
REQ-009 ch_req  input  NUM_CH  per-channel draw request, level.
REQ-010 draw_done  input  1  renderer completion pulse; sampled only in DRAW.
REQ-011 cur_state  output  STATE_W  state code presented to the renderer.
REQ-012 cur_ch  output  clog2(NUM_CH)  index of the granted channel.
REQ-013 ch_grant  output  NUM_CH  one-hot grant vector.
REQ-014 draw_valid  output  1  cur_state and cur_ch are valid for rendering.
REQ-015 started  output  1  sticky flag set when the start key is seen.
REQ-016 game_over  output  1  sticky flag set when a collision is accepted.
REQ-017 draw_timeout  output  1  one-cycle pulse when a draw is aborted by timeout.

Function
REQ-018 The FSM SHALL have four states: IDLE, ARB, DRAW and OVER; all outputs are registered.
REQ-019 IDLE: go_n=0 SHALL set started and move to ARB on the next cycle; collision, ch_req and draw_done are ignored in IDLE.
REQ-020 ARB, grant selection: if any ch_req bit is set, the arbiter SHALL select the first requesting channel searching upward from ptr, wrapping modulo NUM_CH, and enter DRAW on the next cycle.
REQ-021 ARB, no request: with no ch_req bits set, the FSM SHALL remain in ARB.
REQ-022 ARB to DRAW capture: cur_state SHALL capture ch_state of the selected channel; cur_ch, ch_grant and draw_valid=1 are set; all are held stable throughout DRAW regardless of input changes.
REQ-023 ptr SHALL reset to 0 and, on each grant to channel k, update to (k+1) mod NUM_CH; no requesting channel may wait more than NUM_CH-1 grants.
REQ-024 DRAW: draw_done=1 SHALL end the draw, and the next cycle is ARB with draw_valid=0 and ch_grant=0.
REQ-025 DRAW timeout: the watchdog counter SHALL clear on DRAW entry and increment each DRAW cycle; if it reaches TIMEOUT without draw_done, the draw ends as in REQ-024 and draw_timeout pulses for one cycle.
REQ-026 Collision in ARB: collision=1 SHALL set game_over and enter OVER on the next cycle; no new grant is issued in that cycle.
REQ-027 Collision in DRAW: collision=1 SHALL be latched and the current draw completed via draw_done or timeout, then the FSM enters OVER instead of ARB.
REQ-028 OVER: draw_valid=0, ch_grant=0 and game_over=1 SHALL be held; all inputs except resetn are ignored; exit is by reset only.
REQ-029 A simultaneous draw_done and collision in DRAW SHALL result in OVER on the next cycle with game_over=1.
REQ-030 The arbiter SHALL never assert draw_valid in IDLE or OVER, and ch_grant SHALL be all-zero or exactly one-hot.

Reset
REQ-031 While resetn=0 at a rising edge, the FSM SHALL enter IDLE and clear cur_state, cur_ch, ch_grant, draw_valid, started, game_over, draw_timeout, ptr, the watchdog counter and the latched collision, regardless of the current state.
REQ-032 Assertion of reset mid-DRAW SHALL drop draw_valid on the following cycle with no draw_timeout pulse.

Verification
REQ-033 NUM_CH=2: reset; go_n=0 at cycle 1; ch_req=11; ch_state={4'hB,4'h9} -> cycle 2 ARB; cycle 3 draw_valid=1, cur_ch=0, cur_state=9, ch_grant=01.
REQ-034 Continuing REQ-033: draw_done at cycle 5 -> cycle 6 ARB; cycle 7 cur_ch=1, cur_state=B, ch_grant=10; the next draw after that returns to ch 0 (strict alternation).
REQ-035 NUM_CH=4, ch_req=1010 held -> grant sequence 1,3,1,3; changing ch_state during DRAW leaves cur_state unchanged.
REQ-036 TIMEOUT=3, no draw_done -> draw_valid high for exactly 3 cycles, draw_timeout pulses once, then ARB.
REQ-037 Collision mid-DRAW, draw_done 2 cycles later -> game_over=1 and OVER; draw_valid=0 thereafter despite ch_req; go_n ignored until resetn=0, which returns outputs to all-zero.
